// File: rtl/ex_muldiv_pkg.sv
// Shared aluop encodings and the 32x32->64 multiply helper for the EX-stage mul/div unit.
// Encodings mirror the pipeline's EXE_*_OP definitions.
package ex_muldiv_pkg;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  // Sign-extending to 64 bits first makes the truncated product correct for both signednesses.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    bx = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// Unsigned 32/32 restoring divider, one quotient bit per clock.
// done is high in the cycle whose clock edge retires the final iteration.
module div_core #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  localparam int CW = $clog2(DIV_ITER + 1);

  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   quo_q;
  logic [31:0]   rem_q;
  logic [31:0]   dsr_q;
  logic [32:0]   trial;

  // The partial remainder stays below the divisor, so a non-negative trial fits in 32 bits.
  assign trial = {rem_q, quo_q[31]} - {1'b0, dsr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      cnt_q  <= CW'(DIV_ITER);
      busy_q <= 1'b1;
      quo_q  <= dividend;
      rem_q  <= '0;
      dsr_q  <= divisor;
    end else if (busy_q) begin
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= {rem_q[30:0], quo_q[31]};
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign done      = busy_q && (cnt_q == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: single-cycle MULT, two-cycle MADD/MSUB, iterative DIV.
// Holds the pipeline via stallreq_o until the {HI,LO} result is presented.
//
// state      | meaning
// S_IDLE     | no multi-cycle op in progress; MULT answered combinationally
// S_MAC      | product registered, accumulate with forwarded HI/LO
// S_DIV_BUSY | divider iterating
// S_DONE     | signed-corrected divide result presented and held
import ex_muldiv_pkg::*;

module ex_muldiv #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        stall_ex_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [63:0] result_o,
  output logic        result_valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DIV_BUSY, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] prod_q;
  logic        mac_sub_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        div_zero_q;

  logic        is_mult, is_mac, is_div, is_msub;
  logic        mul_sgn, div_sgn;
  logic [63:0] product;
  logic [63:0] acc;
  logic [31:0] a_mag, b_mag;
  logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;
  logic        div_done;
  logic        div_start, div_ld, prod_ld;

  assign is_mult = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign is_mac  = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                   (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign is_div  = (aluop_i == EXE_DIV_OP)  || (aluop_i == EXE_DIVU_OP);
  assign is_msub = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  assign mul_sgn = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MADD_OP) ||
                   (aluop_i == EXE_MSUB_OP);
  assign div_sgn = (aluop_i == EXE_DIV_OP);

  // One multiplier serves both the MULT result and the MADD/MSUB product register.
  assign product = mul64(reg1_i, reg2_i, mul_sgn);
  assign acc     = {hi_i, lo_i};

  // Negating 0x80000000 yields 0x80000000, which read unsigned is the required 2^31.
  assign a_mag = (div_sgn && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
  assign b_mag = (div_sgn && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;

  assign quo_fix = q_neg_q ? (32'd0 - quo_raw) : quo_raw;
  assign rem_fix = r_neg_q ? (32'd0 - rem_raw) : rem_raw;

  div_core #(.DIV_ITER(DIV_ITER)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo_raw),
    .remainder (rem_raw),
    .done      (div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prod_q     <= '0;
      mac_sub_q  <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (prod_ld) begin
        prod_q    <= product;
        mac_sub_q <= is_msub;
      end
      if (div_ld) begin
        q_neg_q    <= div_sgn && (reg1_i[31] ^ reg2_i[31]);
        r_neg_q    <= div_sgn && reg1_i[31];
        div_zero_q <= (reg2_i == 32'd0);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    stallreq_o     = 1'b0;
    result_valid_o = 1'b0;
    result_o       = '0;
    div_start      = 1'b0;
    div_ld         = 1'b0;
    prod_ld        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_mult) begin
          result_o       = product;
          result_valid_o = 1'b1;
        end else if (is_mac) begin
          stallreq_o = 1'b1;
          prod_ld    = 1'b1;
          state_d    = S_MAC;
        end else if (is_div) begin
          stallreq_o = 1'b1;
          div_ld     = 1'b1;
          if (reg2_i == 32'd0) begin
            state_d = S_DONE;
          end else begin
            div_start = 1'b1;
            state_d   = S_DIV_BUSY;
          end
        end
      end
      S_MAC: begin
        result_o       = mac_sub_q ? (acc - prod_q) : (acc + prod_q);
        result_valid_o = 1'b1;
        state_d        = S_IDLE;
      end
      S_DIV_BUSY: begin
        stallreq_o = 1'b1;
        if (div_done) state_d = S_DONE;
      end
      S_DONE: begin
        result_o       = div_zero_q ? 64'd0 : {rem_fix, quo_fix};
        result_valid_o = 1'b1;
        if (!stall_ex_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d   = S_IDLE;
      div_start = 1'b0;
      div_ld    = 1'b0;
      prod_ld   = 1'b0;
    end

    // Outputs are forced quiet for the whole reset pulse, whatever aluop_i shows.
    if (rst) begin
      stallreq_o     = 1'b0;
      result_valid_o = 1'b0;
      result_o       = '0;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: the driver pushes expected {HI,LO} and cycle per op,
// the monitor pops on every valid cycle; reference results come from plain integer arithmetic.
import ex_muldiv_pkg::*;

module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
  logic        stall_ex_i, flush_i;
  logic        stallreq_o;
  logic [63:0] result_o;
  logic        result_valid_o;

  ex_muldiv #(.DIV_ITER(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .aluop_i        (aluop_i),
    .reg1_i         (reg1_i),
    .reg2_i         (reg2_i),
    .hi_i           (hi_i),
    .lo_i           (lo_i),
    .stall_ex_i     (stall_ex_i),
    .flush_i        (flush_i),
    .stallreq_o     (stallreq_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
    end
  endtask

  // Reference: MIPS semantics straight from integer arithmetic on 64-bit values.
  function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [63:0] res, output int lat, output bit has);
    longint      sa, sb, q, r;
    logic [63:0] acc, sp, up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {hi, lo};
    sp  = sa * sb;
    up  = {32'b0, a} * {32'b0, b};
    res = '0;
    lat = 0;
    has = 1'b1;
    case (op)
      EXE_MULT_OP:  res = sp;
      EXE_MULTU_OP: res = up;
      EXE_MADD_OP:  begin lat = 1; res = acc + sp; end
      EXE_MADDU_OP: begin lat = 1; res = acc + up; end
      EXE_MSUB_OP:  begin lat = 1; res = acc - sp; end
      EXE_MSUBU_OP: begin lat = 1; res = acc - up; end
      EXE_DIV_OP, EXE_DIVU_OP: begin
        lat = (b == 32'd0) ? 1 : 33;
        if (b != 32'd0) begin
          if (op == EXE_DIV_OP) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          res = {r[31:0], q[31:0]};
        end
      end
      default: has = 1'b0;
    endcase
  endfunction

  // Present one instruction, held for as long as the unit stalls plus hold extra DONE cycles.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int hold);
    logic [63:0] res;
    int          lat;
    bit          has;
    int          c0;
    model(op, a, b, hi, lo, res, lat, has);
    @(posedge clk);
    #1;
    aluop_i = op; reg1_i = a; reg2_i = b; hi_i = hi; lo_i = lo;
    c0 = cyc;
    if (has) for (int k = 0; k <= hold; k++) sb_q.push_back('{res, c0 + lat + k});
    for (int k = 0; k <= lat + hold; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      stall_ex_i = (k >= lat) && (k < lat + hold);
      @(negedge clk);
      check("stallreq", 64'(stallreq_o), 64'(k < lat));
    end
    stall_ex_i = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (result_valid_o) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid at cycle %0d: got %h want no result", cyc, result_o);
        end else begin
          e = sb_q.pop_front();
          check("result", result_o, e.res);
          check("latency", 64'(cyc), 64'(e.cyc));
        end
      end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_valid at cycle %0d: got none want %h", cyc, sb_q[0].res);
        e = sb_q.pop_front();
      end
    end
  end

  logic [7:0] op_tab [9];

  initial begin
    op_tab = '{EXE_MULT_OP, EXE_MULTU_OP, EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP,
               EXE_MSUBU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_NOP_OP};
    rst = 1'b1;
    aluop_i = EXE_DIV_OP; reg1_i = 32'd9; reg2_i = 32'd2; hi_i = '0; lo_i = '0;
    stall_ex_i = 1'b0; flush_i = 1'b0;
    #3;
    check("reset_stallreq", 64'(stallreq_o), 64'd0);
    check("reset_valid", 64'(result_valid_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    aluop_i = EXE_NOP_OP;
    #20;
    rst = 1'b0;

    issue(EXE_DIV_OP,  32'd7,          32'hFFFF_FFFE, 32'd0, 32'd0, 0);
    issue(EXE_DIVU_OP, 32'hFFFF_FFFF,  32'h10,        32'd0, 32'd0, 0);
    issue(EXE_DIV_OP,  32'd5,          32'd0,         32'd0, 32'd0, 0);
    issue(EXE_NOP_OP,  32'd0,          32'd0,         32'd0, 32'd0, 0);
    issue(EXE_MADD_OP, 32'hFFFF_FFFE,  32'd3,         32'd0, 32'd5, 0);
    issue(EXE_MULT_OP, 32'h8000_0000,  32'd2,         32'd0, 32'd0, 0);
    issue(EXE_MSUBU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 0);
    issue(EXE_DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0, 32'd0, 0);
    issue(EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2,         32'd0, 32'd0, 0);
    issue(EXE_DIVU_OP, 32'd100,        32'd7,         32'd0, 32'd0, 3);

    // Flush in DIV_BUSY cycle 10, then a clean DIVU.
    @(posedge clk);
    #1;
    aluop_i = EXE_DIV_OP; reg1_i = 32'd1000; reg2_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_cycle_stall", 64'(stallreq_o), 64'd1);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("post_flush_stall", 64'(stallreq_o), 64'd0);
    check("post_flush_valid", 64'(result_valid_o), 64'd0);
    issue(EXE_DIVU_OP, 32'd1000, 32'd3, 32'd0, 32'd0, 0);

    // Reset pulse in the middle of a division.
    @(posedge clk);
    #1;
    aluop_i = EXE_DIV_OP; reg1_i = 32'h1234_5678; reg2_i = 32'd9;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_stall", 64'(stallreq_o), 64'd0);
    check("midrst_valid", 64'(result_valid_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    aluop_i = EXE_NOP_OP;
    @(negedge clk);
    #2;
    rst = 1'b0;
    issue(EXE_DIV_OP, 32'h1234_5678, 32'hFFFF_FFF7, 32'd0, 32'd0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      int          hold;
      op = op_tab[$urandom_range(0, 8)];
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      hold = (op == EXE_DIV_OP || op == EXE_DIVU_OP) ? $urandom_range(0, 2) : 0;
      issue(op, a, b, $urandom, $urandom, hold);
    end

    issue(EXE_NOP_OP, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
